// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staged reset sequencer.
//   rs_state_e  : sequencer FSM states
//   cnt_width() : width of the hold/gap counter for a given HOLD/GAP pair
//   RS_COUNT_W  : width of the optional software-reset event counter
package reset_seq_pkg;

    typedef enum logic [1:0] {
        RS_RESET = 2'd0,
        RS_HOLD  = 2'd1,
        RS_STAGE = 2'd2,
        RS_DONE  = 2'd3
    } rs_state_e;

    localparam int RS_COUNT_W = 8;

    // Enough bits to hold max(hold, gap) without wrapping.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// Reset synchroniser: asserts asynchronously with rst_ni, releases
// synchronously STAGES rising edges after rst_ni goes high.
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset
//   sync_no out  synchronised release, high once the chain has filled
module reset_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic sync_no
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b1};
        end
    end

    assign sync_no = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller for a single clock domain. Resets assert
// asynchronously and are released one at a time, bit 0 first, after a
// hold period and then one every STAGE_GAP cycles.
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low board reset (wins over everything)
//   sw_rst_i     in   synchronous software reset request, active-high
//   rst_no       out  NUM_OUTPUTS staged active-low resets, all flop-driven
//   done_o       out  high when every rst_no bit is released
//   rst_count_o  out  saturating count of sw reset requests (only when the
//                     RESET_SEQ_CNT_EN macro is defined)
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUTPUTS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sw_rst_i,
    output logic [NUM_OUTPUTS-1:0] rst_no,
    output logic                   done_o
`ifdef RESET_SEQ_CNT_EN
    ,
    output logic [RS_COUNT_W-1:0]  rst_count_o
`endif
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [NUM_OUTPUTS-1:0] LSB = NUM_OUTPUTS'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (NUM_OUTPUTS < 1) begin : g_bad_num
        $error("reset_sequencer: NUM_OUTPUTS must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
        $error("reset_sequencer: STAGE_GAP must be >= 1");
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    rs_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_OUTPUTS-1:0] rst_q, rst_d;
    logic                   done_q, done_d;
    logic [NUM_OUTPUTS-1:0] nxt_mask;
    logic                   sync_n;
    logic                   release_bit;
    logic                   sw_clear;

    reset_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .sync_no (sync_n)
    );

    // Releasing the next bit is a shift-in of a one; the mask is full when
    // the bit being released is the last one.
    assign nxt_mask = (rst_q << 1) | LSB;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RS_RESET;
            cnt_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        release_bit = 1'b0;
        sw_clear    = 1'b0;
        if (state_q != RS_RESET && sw_rst_i) begin
            sw_clear = 1'b1;
            state_d  = RS_HOLD;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                RS_RESET: begin
                    // The edge that sees sync_n high already counts as the
                    // first hold cycle, so a hold of one releases right here.
                    if (sync_n) begin
                        if (HOLD_CYCLES == 1) begin
                            release_bit = 1'b1;
                            state_d     = (&nxt_mask) ? RS_DONE : RS_STAGE;
                            cnt_d       = '0;
                        end else begin
                            state_d = RS_HOLD;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                RS_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        release_bit = 1'b1;
                        state_d     = (&nxt_mask) ? RS_DONE : RS_STAGE;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                RS_STAGE: begin
                    if (cnt_q == GAP_LAST) begin
                        release_bit = 1'b1;
                        state_d     = (&nxt_mask) ? RS_DONE : RS_STAGE;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                RS_DONE: begin
                    state_d = RS_DONE;
                end
                default: begin
                    state_d = RS_RESET;
                end
            endcase
        end
    end

    always_comb begin
        rst_d = rst_q;
        if (sw_clear) begin
            rst_d = '0;
        end else if (release_bit) begin
            rst_d = nxt_mask;
        end
        done_d = (state_d == RS_DONE);
    end

    assign rst_no = rst_q;
    assign done_o = done_q;

`ifdef RESET_SEQ_CNT_EN
    logic                  sw_prev_q;
    logic [RS_COUNT_W-1:0] rst_count_q;

    // Counts rising edges of the sampled request; a held request counts once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_prev_q   <= 1'b0;
            rst_count_q <= '0;
        end else begin
            sw_prev_q <= sw_rst_i;
            if (sw_rst_i && !sw_prev_q && state_q != RS_RESET && rst_count_q != '1) begin
                rst_count_q <= rst_count_q + 1'b1;
            end
        end
    end

    assign rst_count_o = rst_count_q;
`endif

endmodule
